// File: rtl/sram_like_pkg.sv
// Shared SRAM-like bus definitions: transfer sizes, owner tags
// and arbiter states used by the fetch/data bus arbiter.
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [3:0] STARVE_SAT = 4'd15;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sram_like_arbiter.sv
// Two-to-one SRAM-like arbiter: data wins by default, fetch is
// forced through after STARVE_MAX consecutive data wins.
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam bit         FORCE_EN   = (STARVE_MAX != 0);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;

  logic idle;
  logic starved;
  logic win_inst;
  logic win_data;
  logic hs;

  assign idle     = (state_q == ARB_IDLE);
  assign starved  = FORCE_EN && (cnt_q == STARVE_LIM);
  assign win_inst = inst_req && (!data_req || starved);
  assign win_data = data_req && !win_inst;

  assign m_req   = resetn && idle && (win_inst || win_data);
  assign m_wr    = win_inst ? inst_wr    : data_wr;
  assign m_size  = win_inst ? inst_size  : data_size;
  assign m_addr  = win_inst ? inst_addr  : data_addr;
  assign m_wdata = win_inst ? inst_wdata : data_wdata;

  assign hs = m_req && m_addr_ok;

  assign inst_addr_ok = hs && win_inst;
  assign data_addr_ok = hs && win_data;

  // Completion only counts for a transaction accepted since reset.
  assign inst_data_ok = resetn && !idle && m_data_ok
                     && (owner_q == OWN_INST);
  assign data_data_ok = resetn && !idle && m_data_ok
                     && (owner_q == OWN_DATA);

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (hs) begin
          state_d = ARB_BUSY;
          owner_d = win_inst ? OWN_INST : OWN_DATA;
          if (win_inst) begin
            cnt_d = 4'd0;
          end else if (inst_req && cnt_q != STARVE_SAT) begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ARB_BUSY: begin
        if (m_data_ok) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_INST;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed + random bench for sram_like_arbiter, two instances
// (STARVE_MAX 2 and 0) checked each cycle against a reference model.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] m_rdata;
  logic        m_addr_ok, m_data_ok;

  logic [1:0]        o_i_aok, o_i_dok, o_d_aok, o_d_dok;
  logic [1:0]        o_mreq, o_mwr;
  logic [1:0][1:0]   o_msize;
  logic [1:0][31:0]  o_maddr, o_mwdata, o_i_rd, o_d_rd;

  int checks = 0;
  int failures = 0;

  bit busy [2];
  bit own_i [2];
  int streak [2];
  int nmax [2] = '{2, 0};
  int grants_a [$];

  always #5 clk = ~clk;

  sram_like_arbiter #(.STARVE_MAX(2)) dut_a (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_rdata(o_i_rd[0]), .inst_addr_ok(o_i_aok[0]),
    .inst_data_ok(o_i_dok[0]),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(o_d_rd[0]), .data_addr_ok(o_d_aok[0]),
    .data_data_ok(o_d_dok[0]),
    .m_req(o_mreq[0]), .m_wr(o_mwr[0]), .m_size(o_msize[0]),
    .m_addr(o_maddr[0]), .m_wdata(o_mwdata[0]),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
  );

  sram_like_arbiter #(.STARVE_MAX(0)) dut_b (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_rdata(o_i_rd[1]), .inst_addr_ok(o_i_aok[1]),
    .inst_data_ok(o_i_dok[1]),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(o_d_rd[1]), .data_addr_ok(o_d_aok[1]),
    .data_data_ok(o_d_dok[1]),
    .m_req(o_mreq[1]), .m_wr(o_mwr[1]), .m_size(o_msize[1]),
    .m_addr(o_maddr[1]), .m_wdata(o_mwdata[1]),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
  );

  task automatic chk(string tag, int d, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s[%0d] got=%h exp=%h", tag, d, act, exp);
    end
  endtask

  task automatic idle_in();
    inst_req = 0; data_req = 0; inst_wr = 0; data_wr = 0;
    inst_size = 2'd2; data_size = 2'd2;
    inst_addr = 0; data_addr = 0; inst_wdata = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  // One clock: check all outputs at negedge, then advance the model.
  task automatic step();
    bit gi, gd, req, hs;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      gi = 0; gd = 0;
      if (!busy[d]) begin
        if (inst_req && !data_req) gi = 1;
        else if (data_req && !inst_req) gd = 1;
        else if (inst_req && data_req) begin
          if (nmax[d] > 0 && streak[d] == nmax[d]) gi = 1;
          else gd = 1;
        end
      end
      req = resetn && (gi || gd);
      hs  = req && m_addr_ok;
      chk("m_req", d, 32'(o_mreq[d]), 32'(req));
      chk("inst_addr_ok", d, 32'(o_i_aok[d]), 32'(hs && gi));
      chk("data_addr_ok", d, 32'(o_d_aok[d]), 32'(hs && gd));
      chk("inst_data_ok", d, 32'(o_i_dok[d]),
          32'(resetn && busy[d] && own_i[d] && m_data_ok));
      chk("data_data_ok", d, 32'(o_d_dok[d]),
          32'(resetn && busy[d] && !own_i[d] && m_data_ok));
      chk("inst_rdata", d, o_i_rd[d], m_rdata);
      chk("data_rdata", d, o_d_rd[d], m_rdata);
      if (req) begin
        chk("m_wr", d, 32'(o_mwr[d]), 32'(gi ? inst_wr : data_wr));
        chk("m_size", d, 32'(o_msize[d]),
            32'(gi ? inst_size : data_size));
        chk("m_addr", d, o_maddr[d], gi ? inst_addr : data_addr);
        chk("m_wdata", d, o_mwdata[d], gi ? inst_wdata : data_wdata);
      end
      if (d == 0 && o_i_aok[0]) grants_a.push_back(1);
      if (d == 0 && o_d_aok[0]) grants_a.push_back(0);
      if (!resetn) begin
        busy[d] = 0; own_i[d] = 1; streak[d] = 0;
      end else if (busy[d]) begin
        if (m_data_ok) busy[d] = 0;
      end else if (hs) begin
        busy[d] = 1;
        own_i[d] = gi;
        if (gi) streak[d] = 0;
        else if (inst_req && streak[d] < 15) streak[d]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_in();
    resetn = 0;
    #1;
    step();
    step();
    resetn = 1;
    step();

    // Single instruction read, completion three cycles later
    inst_req = 1; inst_addr = 32'hBFC0_0000; m_addr_ok = 1;
    step();
    inst_req = 0; m_addr_ok = 0;
    step();
    step();
    m_data_ok = 1; m_rdata = 32'h2402_0001;
    step();
    m_data_ok = 0;
    step();

    // Simultaneous requests: data store goes first
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_wr = 1; data_size = 2'd0;
    data_addr = 32'h8000_0004; data_wdata = 32'hAB; m_addr_ok = 1;
    step();
    data_req = 0; data_wr = 0;
    m_addr_ok = 1;
    step();
    step();
    m_data_ok = 1;
    step();
    m_data_ok = 0;
    step();
    inst_req = 0; m_addr_ok = 0;
    step();
    m_data_ok = 1;
    step();
    m_data_ok = 0;

    // Starvation pattern from a clean counter
    resetn = 0;
    step();
    resetn = 1;
    grants_a.delete();
    inst_req = 1; data_req = 1; inst_addr = 32'h200;
    data_addr = 32'h300; m_addr_ok = 1;
    for (int g = 0; g < 6; g++) begin
      m_data_ok = 0;
      step();
      m_data_ok = 1;
      step();
    end
    begin
      int exp_g [6] = '{0, 0, 1, 0, 0, 1};
      checks++;
      assert (grants_a.size() == 6) else begin
        failures++;
        $error("FAIL grant_count got=%0d exp=6", grants_a.size());
      end
      for (int g = 0; g < 6 && g < grants_a.size(); g++)
        chk("grant_order", g, 32'(grants_a[g]), 32'(exp_g[g]));
    end
    idle_in();
    step();

    // Back-pressure: inst waits behind an outstanding data access
    data_req = 1; data_addr = 32'h400; m_addr_ok = 1;
    step();
    data_req = 0; inst_req = 1; inst_addr = 32'h500;
    step();
    step();
    m_data_ok = 1; m_rdata = 32'hDEAD_BEEF;
    step();
    m_data_ok = 0;
    step();
    idle_in();
    m_data_ok = 1;
    step();
    m_data_ok = 0;

    // Reset mid-transaction, late completion is dropped
    data_req = 1; data_addr = 32'h600; m_addr_ok = 1;
    step();
    data_req = 0; m_addr_ok = 0;
    resetn = 0;
    step();
    resetn = 1;
    step();
    m_data_ok = 1;
    step();
    m_data_ok = 0;
    data_req = 1; data_addr = 32'h700; m_addr_ok = 1;
    step();
    idle_in();
    m_data_ok = 1;
    step();

    // Stray completion in IDLE
    m_data_ok = 1; m_rdata = 32'h1234_5678;
    step();
    m_data_ok = 0;
    step();

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      resetn     = ($urandom_range(0, 49) != 0);
      inst_req   = $urandom_range(0, 2) != 0;
      data_req   = $urandom_range(0, 2) != 0;
      inst_wr    = $urandom_range(0, 1) == 1;
      data_wr    = $urandom_range(0, 1) == 1;
      inst_size  = 2'($urandom_range(0, 2));
      data_size  = 2'($urandom_range(0, 2));
      inst_addr  = $urandom;
      data_addr  = $urandom;
      inst_wdata = $urandom;
      data_wdata = $urandom;
      m_rdata    = $urandom;
      m_addr_ok  = $urandom_range(0, 1) == 1;
      m_data_ok  = $urandom_range(0, 2) == 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Shares one SRAM-like master port between the CPU's instruction-fetch and data-access SRAM-like requesters. The master port feeds the single-outstanding CPU-to-AXI bridge. Data requests win by default; a starvation counter guarantees instruction fetch a grant after a bounded number of consecutive data wins. The arbiter allows one transaction in flight, records its owner, and routes `m_data_ok`/`m_rdata` back to that requester only.

## Interface
- `STARVE_MAX`, default 4: consecutive data grants allowed while `inst_req` is pending before instruction fetch is forced to win. Range 0..15; 0 means strict data priority with no forcing.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset; synchronous and active-low.
- `inst_req` in 1: instruction request.
- `inst_wr` in 1: instruction write flag.
- `inst_size` in 2: 0 byte, 1 half, 2 word.
- `inst_addr` in 32: instruction address.
- `inst_wdata` in 32: instruction write data.
- `inst_rdata` out 32: read data to fetch.
- `inst_addr_ok` out 1: instruction address accepted.
- `inst_data_ok` out 1: instruction transaction complete.
- `data_req` in 1: data request.
- `data_wr` in 1: data write flag.
- `data_size` in 2: data size.
- `data_addr` in 32: data address.
- `data_wdata` in 32: data write data.
- `data_rdata` out 32: read data to load/store unit.
- `data_addr_ok` out 1: data address accepted.
- `data_data_ok` out 1: data transaction complete.
- `m_req` out 1: request to bridge.
- `m_wr` out 1: muxed write flag.
- `m_size` out 2: muxed size.
- `m_addr` out 32: muxed address.
- `m_wdata` out 32: muxed write data.
- `m_rdata` in 32: bridge read data.
- `m_addr_ok` in 1: bridge address accepted.
- `m_data_ok` in 1: bridge transaction complete.

## Operation
- **States.** IDLE (no transaction in flight) and BUSY (one accepted, awaiting `m_data_ok`). Registered `owner` (INST/DATA) and 4-bit `starve_cnt`.
- **Grant in IDLE (combinational).**
  - Only one request asserted: it wins.
  - Both asserted: DATA wins, unless `STARVE_MAX != 0` and `starve_cnt == STARVE_MAX`, in which case INST wins.
- **Master port.** `m_req` = winner's req, gated by state IDLE and `resetn`. `m_wr/size/addr/wdata` are muxed from the winner and, when no winner exists, from DATA.
- **Address handshake.** The winner's `*_addr_ok` = `m_addr_ok && m_req`. The loser's `*_addr_ok` = 0. In BUSY, both `*_addr_ok` = 0.
- **On handshake** (`m_req && m_addr_ok`):
  - `owner` <= winner; state -> BUSY.
  - DATA wins while `inst_req` is high: `starve_cnt` += 1, saturating at 15.
  - INST wins: `starve_cnt` <= 0.
  - DATA wins with `inst_req` low: `starve_cnt` unchanged.
- **Completion in BUSY.** `m_data_ok` asserts `inst_data_ok` or `data_data_ok` for the owner, in the same cycle (combinational), then state -> IDLE.
- **Read data.** `inst_rdata` = `data_rdata` = `m_rdata`, unconditionally; it is valid only with the respective data_ok.
- **Boundaries.**
  - `m_data_ok` in IDLE is ignored: no data_ok is asserted.
  - `m_addr_ok` in BUSY has no effect.
  - A requester that drops req before addr_ok loses nothing, and the counter does not move.
- **Reset** (`resetn` low at a clock edge):
  - state IDLE, `owner` INST, `starve_cnt` 0.
  - While `resetn` is low, `m_req`, all `*_addr_ok` and all `*_data_ok` are forced to 0.
  - Reset during BUSY abandons the transaction; a late `m_data_ok` after reset is ignored.

## Timing
- **Request path.** IDLE request to `m_req` is combinational (0 cycles). `addr_ok` is returned in the same cycle as `m_addr_ok`.
- **Completion path.** `m_data_ok` to requester `*_data_ok` is combinational.
- **Back-to-back.** The earliest next `m_req` is in the cycle after `m_data_ok`. The minimum issue interval is therefore 2 cycles plus bridge latency.
- **Starvation bound.** With `STARVE_MAX = N > 0` and both requesters continuously asserting, grant order is N DATA then 1 INST, repeating.

## Structure
- **Shared package `sram_like_pkg`:**
  - size constants SIZE_BYTE = 2'd0, SIZE_HALF = 2'd1, SIZE_WORD = 2'd2;
  - owner enum OWN_INST/OWN_DATA;
  - arbiter state enum ARB_IDLE/ARB_BUSY.
- **Sub-modules:** none; the request mux, grant logic and counter live in this module.

## Test plan
- **Single inst read.** `inst_req`, addr 0xBFC0_0000, word; bridge gives `m_addr_ok` at cycle 0 and `m_data_ok` at cycle 3 with 0x2402_0001.
  - Expected: `inst_addr_ok` at cycle 0; `inst_data_ok` at cycle 3, `inst_rdata` = 0x2402_0001; `data_data_ok` stays 0.
- **Simultaneous requests, `STARVE_MAX = 0`.** Inst 0x100 and data write 0x8000_0004 byte with wdata 0xAB.
  - Expected: data granted first with `m_wr` = 1, `m_size` = 0. Inst is granted the cycle after data's `m_data_ok`.
- **Starvation, `STARVE_MAX = 2`.** Both requesters held high for 6 grants.
  - Expected: grant order D, D, I, D, D, I; `starve_cnt` returns to 0 after each I.
- **Routing under back-pressure.** In BUSY(owner DATA), assert a new `inst_req`, with `m_addr_ok` held at 1.
  - Expected: `inst_addr_ok` = 0 and `m_req` = 0 until `m_data_ok`; then `data_data_ok` pulses, and inst issues next cycle.
- **Reset mid-transaction.** Drop `resetn` for 1 cycle in BUSY; bridge pulses `m_data_ok` 2 cycles later.
  - Expected: state IDLE after reset; no `*_data_ok` asserted; the next `data_req` is accepted normally.
- **Stray completion.** `m_data_ok` pulse in IDLE with no requests.
  - Expected: both data_ok stay 0; state stays IDLE.
